// File: rtl/vector_row_bram.sv
// vector_row_bram: banked vector-row memory with two read ports and one
// element-masked write port. After reset or clr it sweeps every row to zero
// and only then raises ready.
// Optional feature: define VROW_OUT_REG_EN to add one more output register
// stage, which makes the read latency one cycle longer.
module vector_row_bram #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_ELEMENTS = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clr,
  output logic                                 ready,
  input  logic                                 rd_en,
  input  logic [ADDR_WIDTH-1:0]                addr_a,
  input  logic [ADDR_WIDTH-1:0]                addr_b,
  output logic [DATA_WIDTH*NUM_ELEMENTS-1:0]   row_A,
  output logic [DATA_WIDTH*NUM_ELEMENTS-1:0]   row_B,
  output logic                                 rd_valid,
  input  logic                                 wr_en,
  input  logic [ADDR_WIDTH-1:0]                addr_r,
  input  logic [NUM_ELEMENTS-1:0]              wr_mask,
  input  logic [DATA_WIDTH*NUM_ELEMENTS-1:0]   R
);

  localparam int W     = DATA_WIDTH * NUM_ELEMENTS;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    INIT,
    READY
  } state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] cnt, cnt_next;

  logic [W-1:0] mem [DEPTH];

  logic         rd_acc;
  logic         wr_acc;
  logic [W-1:0] bit_mask;
  logic [W-1:0] fwd_a;
  logic [W-1:0] fwd_b;

  logic         s1_valid;
  logic [W-1:0] s1_a;
  logic [W-1:0] s1_b;

  logic         pipe_valid;
  logic [W-1:0] pipe_a;
  logic [W-1:0] pipe_b;

  // State register and sweep counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: sweep all rows in INIT, leave READY on clr
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      INIT: begin
        if (clr) begin
          cnt_next = '0;
        end else if (cnt == '1) begin
          state_next = READY;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      READY: begin
        if (clr) begin
          state_next = INIT;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = INIT;
        cnt_next   = '0;
      end
    endcase
  end

  assign ready  = (state == READY);
  assign rd_acc = (state == READY) && rd_en;
  // A write coinciding with clr is dropped; the read in that cycle is not
  assign wr_acc = (state == READY) && wr_en && !clr;

  // Expand the element mask to a per-bit mask
  always_comb begin
    bit_mask = '0;
    for (int unsigned i = 0; i < NUM_ELEMENTS; i++) begin
      bit_mask[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{wr_mask[i]}};
    end
  end

  // Write-first forwarding: a read hitting the row being written sees the merge
  always_comb begin
    fwd_a = mem[addr_a];
    fwd_b = mem[addr_b];
    if (wr_acc && (addr_r == addr_a)) begin
      fwd_a = (mem[addr_a] & ~bit_mask) | (R & bit_mask);
    end
    if (wr_acc && (addr_r == addr_b)) begin
      fwd_b = (mem[addr_b] & ~bit_mask) | (R & bit_mask);
    end
  end

  // Memory array: zero sweep in INIT, element-masked writes in READY (not reset)
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[cnt] <= '0;
    end else if (wr_acc) begin
      for (int unsigned i = 0; i < NUM_ELEMENTS; i++) begin
        if (wr_mask[i]) begin
          mem[addr_r][i*DATA_WIDTH +: DATA_WIDTH] <= R[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // First read stage: capture the (forwarded) rows at the request edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= rd_acc;
      if (rd_acc) begin
        s1_a <= fwd_a;
        s1_b <= fwd_b;
      end
    end
  end

`ifdef VROW_OUT_REG_EN
  logic         s2_valid;
  logic [W-1:0] s2_a;
  logic [W-1:0] s2_b;

  // Optional extra pipeline stage; clr does not flush it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_a     <= '0;
      s2_b     <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_a <= s1_a;
        s2_b <= s1_b;
      end
    end
  end

  assign pipe_valid = s2_valid;
  assign pipe_a     = s2_a;
  assign pipe_b     = s2_b;
`else
  assign pipe_valid = s1_valid;
  assign pipe_a     = s1_a;
  assign pipe_b     = s1_b;
`endif

  // Output register: rows hold their last value when no result arrives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      row_A    <= '0;
      row_B    <= '0;
    end else begin
      rd_valid <= pipe_valid;
      if (pipe_valid) begin
        row_A <= pipe_a;
        row_B <= pipe_b;
      end
    end
  end

endmodule

// File: tb/tb_vector_row_bram.sv
// Directed testbench for vector_row_bram with a 16-row memory.
module tb_vector_row_bram;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NE = 4;
  localparam int W  = DW * NE;
  localparam int DEPTH = 1 << AW;
`ifdef VROW_OUT_REG_EN
  localparam int RD_EDGES = 3;
`else
  localparam int RD_EDGES = 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          ready;
  logic          rd_en = 1'b0;
  logic [AW-1:0] addr_a = '0;
  logic [AW-1:0] addr_b = '0;
  logic [W-1:0]  row_A;
  logic [W-1:0]  row_B;
  logic          rd_valid;
  logic          wr_en = 1'b0;
  logic [AW-1:0] addr_r = '0;
  logic [NE-1:0] wr_mask = '0;
  logic [W-1:0]  R = '0;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [W-1:0] ROW3_FULL = 128'h44444444_33333333_22222222_11111111;
  localparam logic [W-1:0] ROW3_MASK = 128'h44444444_AAAAAAAA_22222222_AAAAAAAA;
  localparam logic [W-1:0] ROW7_OLD  = 128'h77777777_66666666_55555555_44444444;
  localparam logic [W-1:0] ROW7_NEW  = 128'h77777777_66666666_DEADBEEF_44444444;
  localparam logic [W-1:0] ROW4_VAL  = 128'h0BADF00D_CAFEBABE_12345678_9ABCDEF0;

  vector_row_bram #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .NUM_ELEMENTS(NE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .ready   (ready),
    .rd_en   (rd_en),
    .addr_a  (addr_a),
    .addr_b  (addr_b),
    .row_A   (row_A),
    .row_B   (row_B),
    .rd_valid(rd_valid),
    .wr_en   (wr_en),
    .addr_r  (addr_r),
    .wr_mask (wr_mask),
    .R       (R)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [NE-1:0] m, input logic [W-1:0] d);
    addr_r  = a;
    wr_mask = m;
    R       = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [W-1:0] exp_a, input logic [W-1:0] exp_b);
    addr_a = a;
    addr_b = b;
    rd_en  = 1'b1;
    tick();
    rd_en  = 1'b0;
    for (int k = 1; k < RD_EDGES; k++) begin
      check({tag, "_early_valid"}, W'(rd_valid), W'(1'b0));
      tick();
    end
    check({tag, "_valid"}, W'(rd_valid), W'(1'b1));
    check({tag, "_row_A"}, row_A, exp_a);
    check({tag, "_row_B"}, row_B, exp_b);
    tick();
    check({tag, "_valid_drop"}, W'(rd_valid), W'(1'b0));
    check({tag, "_hold_A"}, row_A, exp_a);
  endtask

  task automatic sweep_wait(input string tag);
    for (int i = 1; i <= DEPTH; i++) begin
      tick();
      if (i == DEPTH - 1) check({tag, "_ready_low"}, W'(ready), W'(1'b0));
      if (i == DEPTH)     check({tag, "_ready_high"}, W'(ready), W'(1'b1));
    end
  endtask

  initial begin
    // Reset
    #1 rst = 1'b1;
    #1;
    check("rst_ready", W'(ready), W'(1'b0));
    check("rst_valid", W'(rd_valid), W'(1'b0));
    check("rst_row_A", row_A, '0);
    check("rst_row_B", row_B, '0);
    tick();
    tick();
    rst = 1'b0;

    // Sweep with rd_en/wr_en held high throughout INIT: both must be ignored
    rd_en   = 1'b1;
    addr_a  = 4'd2;
    addr_b  = 4'd2;
    wr_en   = 1'b1;
    addr_r  = 4'd2;
    wr_mask = 4'b1111;
    R       = '1;
    for (int i = 1; i <= DEPTH; i++) begin
      tick();
      if (i == 8)         check("init_no_valid_mid", W'(rd_valid), W'(1'b0));
      if (i == DEPTH - 1) check("init_ready_low", W'(ready), W'(1'b0));
      if (i == DEPTH) begin
        check("init_ready_high", W'(ready), W'(1'b1));
        check("init_no_valid_end", W'(rd_valid), W'(1'b0));
        rd_en = 1'b0;
        wr_en = 1'b0;
      end
    end
    tick();
    check("init_no_valid_after", W'(rd_valid), W'(1'b0));

    do_read("rd5_zero", 4'd5, 4'd5, '0, '0);
    do_read("rd2_unchanged", 4'd2, 4'd5, '0, '0);

    // Full write then dual-port read of the same row
    do_write(4'd3, 4'b1111, ROW3_FULL);
    do_read("rd3_full", 4'd3, 4'd3, ROW3_FULL, ROW3_FULL);

    // Masked write merges into existing row
    do_write(4'd3, 4'b0101, {4{32'hAAAAAAAA}});
    do_read("rd3_masked", 4'd3, 4'd3, ROW3_MASK, ROW3_MASK);

    // Zero mask is a no-op
    do_write(4'd3, 4'b0000, '1);
    do_read("rd3_nomask", 4'd3, 4'd2, ROW3_MASK, '0);

    // Read-during-write to the same row returns the merged row
    do_write(4'd7, 4'b1111, ROW7_OLD);
    addr_r  = 4'd7;
    wr_mask = 4'b0010;
    R       = 128'hFFFFFFFF_FFFFFFFF_DEADBEEF_FFFFFFFF;
    wr_en   = 1'b1;
    addr_a  = 4'd7;
    addr_b  = 4'd3;
    rd_en   = 1'b1;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    for (int k = 1; k < RD_EDGES; k++) tick();
    check("rdw_valid", W'(rd_valid), W'(1'b1));
    check("rdw_row_A", row_A, ROW7_NEW);
    check("rdw_row_B", row_B, ROW3_MASK);
    do_read("rd7_after", 4'd7, 4'd7, ROW7_NEW, ROW7_NEW);

    // clr in READY with a read (completes) and a write (dropped) in the same cycle
    clr     = 1'b1;
    rd_en   = 1'b1;
    addr_a  = 4'd3;
    addr_b  = 4'd7;
    wr_en   = 1'b1;
    addr_r  = 4'd9;
    wr_mask = 4'b1111;
    R       = '1;
    tick();
    clr   = 1'b0;
    rd_en = 1'b0;
    wr_en = 1'b0;
    check("clr_ready_fall", W'(ready), W'(1'b0));
    for (int i = 1; i <= DEPTH; i++) begin
      tick();
      if (i == RD_EDGES - 1) begin
        check("clr_rd_valid", W'(rd_valid), W'(1'b1));
        check("clr_rd_row_A", row_A, ROW3_MASK);
        check("clr_rd_row_B", row_B, ROW7_NEW);
      end
      if (i == RD_EDGES)  check("clr_rd_once", W'(rd_valid), W'(1'b0));
      if (i == DEPTH - 1) check("clr_ready_low", W'(ready), W'(1'b0));
      if (i == DEPTH)     check("clr_ready_high", W'(ready), W'(1'b1));
    end
    do_read("clr_rd3_7", 4'd3, 4'd7, '0, '0);
    do_read("clr_rd9", 4'd9, 4'd9, '0, '0);

    // Async reset mid-sweep at count 9
    do_write(4'd4, 4'b1111, ROW4_VAL);
    do_read("rd4", 4'd4, 4'd4, ROW4_VAL, ROW4_VAL);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    #1;
    check("arst_row_A", row_A, '0);
    check("arst_row_B", row_B, '0);
    check("arst_valid", W'(rd_valid), W'(1'b0));
    check("arst_ready", W'(ready), W'(1'b0));
    tick();
    rst = 1'b0;
    sweep_wait("arst_sweep");
    do_read("arst_rd4", 4'd4, 4'd4, '0, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
